// File: rtl/jac_pkg.sv
// Shared definitions for the instruction fetch unit: default widths and FSM state encodings.
package jac_pkg;

    localparam int unsigned JAC_PC_WIDTH   = 8;
    localparam int unsigned JAC_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HOLD   = 2'd2,
        HALTED = 2'd3
    } fetch_state_e;

endpackage : jac_pkg

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding a fetched word and its address while the decoder stalls.
// Flush wins over load; a load in the same cycle as a pop replaces the entry.
module fetch_skid
    import jac_pkg::*;
#(
    parameter int unsigned PC_WIDTH   = JAC_PC_WIDTH,
    parameter int unsigned DATA_WIDTH = JAC_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  load_i,
    input  logic                  pop_i,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [PC_WIDTH-1:0]   pc_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [PC_WIDTH-1:0]   pc_o,
    output logic                  valid_o
);

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic                  valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            data_d  = data_i;
            pc_d    = pc_i;
            valid_d = 1'b1;
        end else if (pop_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            data_q  <= '0;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign pc_o    = pc_q;
    assign valid_o = valid_q;

endmodule : fetch_skid

// File: rtl/instr_fetch.sv
// Instruction fetch unit: sequential PC, one-cycle memory latency, ready/valid output with skid.
// Define JAC_REL_JMP_EN to add the jmp_rel input for instr_pc-relative jump targets.
module instr_fetch
    import jac_pkg::*;
#(
    parameter int unsigned PC_WIDTH   = JAC_PC_WIDTH,
    parameter int unsigned DATA_WIDTH = JAC_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  res,
    output logic [PC_WIDTH-1:0]   pc,
    input  logic [DATA_WIDTH-1:0] ir,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]   instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  jmp_en,
    input  logic [PC_WIDTH-1:0]   jmp_addr,
`ifdef JAC_REL_JMP_EN
    input  logic                  jmp_rel,
`endif
    input  logic                  halt,
    output logic                  halted
);

    fetch_state_e state_q, state_d;

    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic                  inf_v_q, inf_v_d;
    logic [PC_WIDTH-1:0]   inf_pc_q, inf_pc_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [PC_WIDTH-1:0]   instr_pc_q, instr_pc_d;
    logic                  valid_q, valid_d;
    logic                  halted_q, halted_d;

    logic                  stall_c;
    logic                  fetch_en_c;
    logic                  issue_c;
    logic [PC_WIDTH-1:0]   jmp_target_c;
    logic                  skid_load_c, skid_pop_c, skid_flush_c;
    logic                  skid_v;
    logic [DATA_WIDTH-1:0] skid_data;
    logic [PC_WIDTH-1:0]   skid_pc;

    assign stall_c = valid_q && !instr_ready;

    // Offset has the same width as the PC, so sign extension is the identity and the add wraps.
`ifdef JAC_REL_JMP_EN
    assign jmp_target_c = jmp_rel ? PC_WIDTH'(instr_pc_q + jmp_addr) : jmp_addr;
`else
    assign jmp_target_c = jmp_addr;
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inf_v_d      = 1'b0;
        inf_pc_d     = inf_pc_q;
        instr_d      = instr_q;
        instr_pc_d   = instr_pc_q;
        valid_d      = valid_q;
        fetch_en_c   = 1'b0;
        issue_c      = 1'b0;
        skid_load_c  = 1'b0;
        skid_pop_c   = 1'b0;
        skid_flush_c = 1'b0;

        case (state_q)
            IDLE: begin
                fetch_en_c = 1'b1;
                state_d    = RUN;
            end
            RUN: begin
                fetch_en_c = !halt;
                if (halt) begin
                    state_d = HALTED;
                end else if (stall_c && inf_v_q) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                fetch_en_c = !halt;
                if (halt) begin
                    state_d = HALTED;
                end else if (!stall_c) begin
                    state_d = RUN;
                end
            end
            HALTED: begin
                fetch_en_c = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The address on pc counts as fetched only when it is allowed to advance.
        issue_c = fetch_en_c && !stall_c;
        if (issue_c) begin
            pc_d     = PC_WIDTH'(pc_q + PC_WIDTH'(1));
            inf_v_d  = 1'b1;
            inf_pc_d = pc_q;
        end

        // Output refill: the skid is older than the in-flight word, so it drains first.
        if (!stall_c) begin
            if (skid_v) begin
                instr_d    = skid_data;
                instr_pc_d = skid_pc;
                valid_d    = 1'b1;
                skid_pop_c = 1'b1;
            end else if (inf_v_q) begin
                instr_d    = ir;
                instr_pc_d = inf_pc_q;
                valid_d    = 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end
        skid_load_c = inf_v_q && (stall_c || skid_v);

        // A redirect discards every word already fetched and overrides stall and halt.
        if (jmp_en) begin
            state_d      = RUN;
            pc_d         = jmp_target_c;
            inf_v_d      = 1'b0;
            valid_d      = 1'b0;
            skid_flush_c = 1'b1;
            skid_load_c  = 1'b0;
            skid_pop_c   = 1'b0;
        end

        halted_d = (state_d == HALTED);
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            inf_v_q    <= 1'b0;
            inf_pc_q   <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inf_v_q    <= inf_v_d;
            inf_pc_q   <= inf_pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            halted_q   <= halted_d;
        end
    end

    fetch_skid #(
        .PC_WIDTH   (PC_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk     (clk),
        .res     (res),
        .load_i  (skid_load_c),
        .pop_i   (skid_pop_c),
        .flush_i (skid_flush_c),
        .data_i  (ir),
        .pc_i    (inf_pc_q),
        .data_o  (skid_data),
        .pc_o    (skid_pc),
        .valid_o (skid_v)
    );

    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign halted      = halted_q;

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with a one-cycle-latency program memory model.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        res;
    logic [7:0]  pc;
    logic [15:0] ir;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        jmp_en;
    logic [7:0]  jmp_addr;
`ifdef JAC_REL_JMP_EN
    logic        jmp_rel;
`endif
    logic        halt;
    logic        halted;

    logic [15:0] mem [256];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) ir <= mem[pc];

    instr_fetch dut (
        .clk         (clk),
        .res         (res),
        .pc          (pc),
        .ir          (ir),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .jmp_en      (jmp_en),
        .jmp_addr    (jmp_addr),
`ifdef JAC_REL_JMP_EN
        .jmp_rel     (jmp_rel),
`endif
        .halt        (halt),
        .halted      (halted)
    );

    function automatic logic [15:0] md(input logic [7:0] a);
        return {~a, a};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        res         = 1'b1;
        instr_ready = 1'b1;
        jmp_en      = 1'b0;
        jmp_addr    = 8'h00;
        halt        = 1'b0;
`ifdef JAC_REL_JMP_EN
        jmp_rel     = 1'b0;
`endif
        step(2);
        res = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({pc, instr, instr_pc, instr_valid, halted} !== 34'h0) begin
            errors++;
            $display("FAIL reset: pc=%h instr=%h instr_pc=%h v=%b halted=%b, want all 0",
                     pc, instr, instr_pc, instr_valid, halted);
        end
    endtask

    task automatic test_stream();
        do_reset();
        step(1);
        checks++;
        if (instr_valid !== 1'b0 || pc !== 8'h01) begin
            errors++;
            $display("FAIL stream_first: v=%b pc=%h, want v=0 pc=01", instr_valid, pc);
        end
        for (int k = 2; k <= 6; k++) begin
            step(1);
            checks++;
            if ({instr_valid, instr_pc, instr, pc} !== {1'b1, 8'(k - 2), md(8'(k - 2)), 8'(k)}) begin
                errors++;
                $display("FAIL stream k=%0d: v=%b instr_pc=%h instr=%h pc=%h, want v=1 instr_pc=%h instr=%h pc=%h",
                         k, instr_valid, instr_pc, instr, pc, 8'(k - 2), md(8'(k - 2)), 8'(k));
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        step(6);
        instr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(1);
            checks++;
            if ({instr_valid, instr_pc, instr, pc} !== {1'b1, 8'h04, md(8'h04), 8'h06}) begin
                errors++;
                $display("FAIL stall_hold %0d: v=%b instr_pc=%h instr=%h pc=%h, want v=1 instr_pc=04 pc=06",
                         k, instr_valid, instr_pc, instr, pc);
            end
        end
        instr_ready = 1'b1;
        for (int k = 5; k <= 7; k++) begin
            step(1);
            checks++;
            if ({instr_valid, instr_pc, instr} !== {1'b1, 8'(k), md(8'(k))}) begin
                errors++;
                $display("FAIL stall_release: v=%b instr_pc=%h instr=%h, want v=1 instr_pc=%h instr=%h",
                         instr_valid, instr_pc, instr, 8'(k), md(8'(k)));
            end
        end
    endtask

    task automatic test_jump();
        do_reset();
        step(5);
        checks++;
        if (instr_pc !== 8'h03) begin
            errors++;
            $display("FAIL jump_pre: instr_pc=%h, want 03", instr_pc);
        end
        jmp_en   = 1'b1;
        jmp_addr = 8'h20;
        step(1);
        jmp_en = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || pc !== 8'h20) begin
            errors++;
            $display("FAIL jump_redirect: v=%b pc=%h, want v=0 pc=20", instr_valid, pc);
        end
        step(1);
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL jump_bubble: v=%b, want 0", instr_valid);
        end
        for (int k = 8'h20; k <= 8'h21; k++) begin
            step(1);
            checks++;
            if ({instr_valid, instr_pc, instr} !== {1'b1, 8'(k), md(8'(k))}) begin
                errors++;
                $display("FAIL jump_target: v=%b instr_pc=%h instr=%h, want v=1 instr_pc=%h",
                         instr_valid, instr_pc, instr, 8'(k));
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_seq [4];
        exp_seq = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        do_reset();
        step(2);
        jmp_en   = 1'b1;
        jmp_addr = 8'hFE;
        step(1);
        jmp_en = 1'b0;
        step(1);
        for (int k = 0; k < 4; k++) begin
            step(1);
            checks++;
            if ({instr_valid, instr_pc, instr} !== {1'b1, exp_seq[k], md(exp_seq[k])}) begin
                errors++;
                $display("FAIL wrap %0d: v=%b instr_pc=%h instr=%h, want v=1 instr_pc=%h",
                         k, instr_valid, instr_pc, instr, exp_seq[k]);
            end
            if (k == 0) begin
                checks++;
                if (pc !== 8'h00) begin
                    errors++;
                    $display("FAIL wrap_pc: pc=%h, want 00", pc);
                end
            end
        end
    endtask

    task automatic test_halt();
        do_reset();
        step(8);
        halt = 1'b1;
        step(1);
        checks++;
        if ({instr_valid, instr_pc, instr, halted, pc} !== {1'b1, 8'h07, md(8'h07), 1'b1, 8'h08}) begin
            errors++;
            $display("FAIL halt_drain: v=%b instr_pc=%h instr=%h halted=%b pc=%h, want v=1 instr_pc=07 halted=1 pc=08",
                     instr_valid, instr_pc, instr, halted, pc);
        end
        for (int k = 0; k < 2; k++) begin
            step(1);
            checks++;
            if ({instr_valid, halted, pc} !== {1'b0, 1'b1, 8'h08}) begin
                errors++;
                $display("FAIL halt_idle %0d: v=%b halted=%b pc=%h, want v=0 halted=1 pc=08",
                         k, instr_valid, halted, pc);
            end
        end
        jmp_en   = 1'b1;
        jmp_addr = 8'h10;
        step(1);
        jmp_en = 1'b0;
        halt   = 1'b0;
        checks++;
        if ({instr_valid, halted, pc} !== {1'b0, 1'b0, 8'h10}) begin
            errors++;
            $display("FAIL halt_resume: v=%b halted=%b pc=%h, want v=0 halted=0 pc=10",
                     instr_valid, halted, pc);
        end
        step(2);
        checks++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, 8'h10, md(8'h10)}) begin
            errors++;
            $display("FAIL halt_target: v=%b instr_pc=%h instr=%h, want v=1 instr_pc=10",
                     instr_valid, instr_pc, instr);
        end
    endtask

    task automatic test_jump_in_hold();
        do_reset();
        step(6);
        instr_ready = 1'b0;
        step(2);
        jmp_en   = 1'b1;
        jmp_addr = 8'h40;
        step(1);
        jmp_en = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || pc !== 8'h40) begin
            errors++;
            $display("FAIL hold_jump: v=%b pc=%h, want v=0 pc=40", instr_valid, pc);
        end
        step(2);
        instr_ready = 1'b1;
        checks++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, 8'h40, md(8'h40)}) begin
            errors++;
            $display("FAIL hold_jump_target: v=%b instr_pc=%h instr=%h, want v=1 instr_pc=40",
                     instr_valid, instr_pc, instr);
        end
        step(1);
        checks++;
        if ({instr_valid, instr_pc} !== {1'b1, 8'h41}) begin
            errors++;
            $display("FAIL hold_jump_flush: v=%b instr_pc=%h, want v=1 instr_pc=41",
                     instr_valid, instr_pc);
        end
    endtask

    task automatic test_reset_in_hold();
        do_reset();
        step(6);
        instr_ready = 1'b0;
        step(2);
        res      = 1'b1;
        jmp_en   = 1'b1;
        jmp_addr = 8'h33;
        step(1);
        res         = 1'b0;
        jmp_en      = 1'b0;
        instr_ready = 1'b1;
        checks++;
        if ({pc, instr, instr_pc, instr_valid, halted} !== 34'h0) begin
            errors++;
            $display("FAIL reset_hold: pc=%h instr=%h instr_pc=%h v=%b halted=%b, want all 0",
                     pc, instr, instr_pc, instr_valid, halted);
        end
        step(1);
        checks++;
        if (instr_valid !== 1'b0 || pc !== 8'h01) begin
            errors++;
            $display("FAIL reset_hold_restart: v=%b pc=%h, want v=0 pc=01", instr_valid, pc);
        end
        for (int k = 0; k <= 1; k++) begin
            step(1);
            checks++;
            if ({instr_valid, instr_pc, instr} !== {1'b1, 8'(k), md(8'(k))}) begin
                errors++;
                $display("FAIL reset_hold_seq: v=%b instr_pc=%h instr=%h, want v=1 instr_pc=%h",
                         instr_valid, instr_pc, instr, 8'(k));
            end
        end
    endtask

`ifdef JAC_REL_JMP_EN
    task automatic test_rel_jump();
        do_reset();
        step(10);
        jmp_en   = 1'b1;
        jmp_rel  = 1'b1;
        jmp_addr = 8'hFC;
        step(1);
        jmp_en  = 1'b0;
        jmp_rel = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || pc !== 8'h04) begin
            errors++;
            $display("FAIL rel_jump: v=%b pc=%h, want v=0 pc=04", instr_valid, pc);
        end
        step(2);
        checks++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, 8'h04, md(8'h04)}) begin
            errors++;
            $display("FAIL rel_target: v=%b instr_pc=%h instr=%h, want v=1 instr_pc=04",
                     instr_valid, instr_pc, instr);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = md(8'(i));
        test_reset();
        test_stream();
        test_stall();
        test_jump();
        test_wrap();
        test_halt();
        test_jump_in_hold();
        test_reset_in_hold();
`ifdef JAC_REL_JMP_EN
        test_rel_jump();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_instr_fetch
